// File: rtl/sprite_layer_renderer_pkg.sv
// Shared types and constants for the sprite layer: scale encoding, animation
// FSM states and the fixed pixel-pipeline latency.
package sprite_pkg;

  typedef enum logic [1:0] {
    SCALE_1X = 2'd0,
    SCALE_2X = 2'd1,
    SCALE_4X = 2'd2
  } scale_e;

  typedef enum logic {
    PLAY = 1'b0,
    DONE = 1'b1
  } anim_state_e;

  localparam int SPRITE_PIPE_LAT = 3;

  // Codes 2 and 3 both select 4x.
  function automatic scale_e to_scale(input logic [1:0] code);
    case (code)
      2'd0:    return SCALE_1X;
      2'd1:    return SCALE_2X;
      default: return SCALE_4X;
    endcase
  endfunction

  function automatic logic [1:0] scale_shift(input scale_e s);
    case (s)
      SCALE_1X: return 2'd0;
      SCALE_2X: return 2'd1;
      default:  return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/sprite_layer_renderer_anim_ctrl.sv
// Animation sequencer: divides frame_start pulses and steps the sprite frame,
// either looping or stopping on the last frame.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_DIV  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic                          anim_start,
  input  logic                          anim_en,
  input  logic                          anim_loop,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
  output logic                          anim_done
);

  localparam int FW = $clog2(NUM_FRAMES);
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  anim_state_e   state;
  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PLAY;
      div_cnt   <= '0;
      frame_idx <= '0;
      anim_done <= 1'b0;
    end else if (anim_start) begin
      // Restart takes priority over any step requested in the same cycle.
      state     <= PLAY;
      div_cnt   <= '0;
      frame_idx <= '0;
      anim_done <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          if (anim_en && frame_start) begin
            if (div_cnt == DW'(FRAME_DIV - 1)) begin
              div_cnt <= '0;
              if (frame_idx == FW'(NUM_FRAMES - 1)) begin
                if (anim_loop) begin
                  frame_idx <= '0;
                end else begin
                  state     <= DONE;
                  anim_done <= 1'b1;
                end
              end else begin
                frame_idx <= frame_idx + 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end
        DONE: ;
        default: state <= PLAY;
      endcase
    end
  end

endmodule

// File: rtl/sprite_layer_renderer.sv
// Sprite layer: per-frame shadowed placement, scaled/mirrored hit test,
// ROM address generation and a 3-stage pipeline to the opaque pixel output.
module sprite_layer_renderer
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 64,
  parameter int NUM_FRAMES = 4,
  parameter int IDX_W      = 4,
  parameter int TRANSP_IDX = 0,
  parameter int FRAME_DIV  = 8,
  parameter int ADDR_W     = $clog2(NUM_FRAMES * SPR_W * SPR_H)
) (
  input  logic                          vga_clk,
  input  logic                          reset,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  input  logic                          blank,
  input  logic                          frame_start,
  input  logic [9:0]                    pos_x,
  input  logic [9:0]                    pos_y,
  input  logic                          flip_x,
  input  logic [1:0]                    scale,
  input  logic                          anim_start,
  input  logic                          anim_en,
  input  logic                          anim_loop,
  output logic [ADDR_W-1:0]             rom_address,
  input  logic [IDX_W-1:0]              rom_q,
  output logic [IDX_W-1:0]              pix_idx,
  output logic                          pix_opaque,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
  output logic                          anim_done
);

  localparam int UW = $clog2(SPR_W);
  localparam int VW = $clog2(SPR_H);

  logic [9:0] px_s, py_s;
  logic       flip_s;
  scale_e     scale_s;

  logic [1:0]    sh;
  logic [10:0]   dx, dy, dx_sh, dy_sh, span_x, span_y;
  logic          hit;
  logic [UW-1:0] u, u_m;
  logic [VW-1:0] v;
  logic          hit1, blank1, hit2, blank2;

  sprite_anim_ctrl #(
    .NUM_FRAMES(NUM_FRAMES),
    .FRAME_DIV (FRAME_DIV)
  ) u_anim (
    .clk        (vga_clk),
    .rst        (reset),
    .frame_start(frame_start),
    .anim_start (anim_start),
    .anim_en    (anim_en),
    .anim_loop  (anim_loop),
    .frame_idx  (frame_idx),
    .anim_done  (anim_done)
  );

  // Placement only changes during vertical blanking to avoid tearing.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      px_s    <= '0;
      py_s    <= '0;
      flip_s  <= 1'b0;
      scale_s <= SCALE_1X;
    end else if (frame_start) begin
      px_s    <= pos_x;
      py_s    <= pos_y;
      flip_s  <= flip_x;
      scale_s <= to_scale(scale);
    end
  end

  // 11-bit differences: bit 10 set means the pixel is left of / above the sprite.
  always_comb begin
    sh     = scale_shift(scale_s);
    dx     = {1'b0, DrawX} - {1'b0, px_s};
    dy     = {1'b0, DrawY} - {1'b0, py_s};
    span_x = 11'(SPR_W) << sh;
    span_y = 11'(SPR_H) << sh;
    hit    = !dx[10] && !dy[10] && (dx < span_x) && (dy < span_y);
    dx_sh  = dx >> sh;
    dy_sh  = dy >> sh;
    u      = dx_sh[UW-1:0];
    v      = dy_sh[VW-1:0];
    u_m    = flip_s ? (UW'(SPR_W - 1) - u) : u;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_address <= '0;
      hit1        <= 1'b0;
      blank1      <= 1'b0;
      hit2        <= 1'b0;
      blank2      <= 1'b0;
      pix_idx     <= '0;
      pix_opaque  <= 1'b0;
    end else begin
      rom_address <= hit ? ADDR_W'({frame_idx, v, u_m})
                         : ADDR_W'({frame_idx, {(UW + VW){1'b0}}});
      hit1        <= hit;
      blank1      <= blank;
      hit2        <= hit1;
      blank2      <= blank1;
      if (hit2 && blank2 && (rom_q != IDX_W'(TRANSP_IDX))) begin
        pix_idx    <= rom_q;
        pix_opaque <= 1'b1;
      end else begin
        pix_idx    <= '0;
        pix_opaque <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Directed self-checking bench for sprite_layer_renderer with a behavioural
// 1-cycle-latency ROM that returns a programmable palette index.
module tb_sprite_layer_renderer;
  import sprite_pkg::*;

  localparam int ADDR_W = 14;
  localparam int IDX_W  = 4;

  logic              vga_clk = 1'b0;
  logic              reset;
  logic [9:0]        DrawX, DrawY, pos_x, pos_y;
  logic              blank, frame_start, flip_x;
  logic [1:0]        scale;
  logic              anim_start, anim_en, anim_loop;
  logic [ADDR_W-1:0] rom_address;
  logic [IDX_W-1:0]  rom_q, rom_val;
  logic [IDX_W-1:0]  pix_idx;
  logic              pix_opaque;
  logic [1:0]        frame_idx;
  logic              anim_done;

  int checks = 0;
  int errors = 0;

  sprite_layer_renderer #(
    .SPR_W(64), .SPR_H(64), .NUM_FRAMES(4), .IDX_W(IDX_W),
    .TRANSP_IDX(0), .FRAME_DIV(8)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y),
    .flip_x(flip_x), .scale(scale), .anim_start(anim_start),
    .anim_en(anim_en), .anim_loop(anim_loop), .rom_address(rom_address),
    .rom_q(rom_q), .pix_idx(pix_idx), .pix_opaque(pix_opaque),
    .frame_idx(frame_idx), .anim_done(anim_done)
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) rom_q <= rom_val;

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic load_pos(input int x, input int y, input logic f, input int s);
    pos_x  = 10'(x);
    pos_y  = 10'(y);
    flip_x = f;
    scale  = 2'(s);
    pulse_fs();
  endtask

  task automatic set_pix(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    repeat (SPRITE_PIPE_LAT) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (rom_address !== 14'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", rom_address); end
    checks++; if (pix_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", pix_idx); end
    checks++; if (pix_opaque !== 1'b0) begin errors++; $display("FAIL reset_opaque got %0b want 0", pix_opaque); end
    checks++; if (frame_idx !== 2'd0) begin errors++; $display("FAIL reset_frame got %0d want 0", frame_idx); end
    checks++; if (anim_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", anim_done); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    rom_val = 4'd5;
    blank   = 1'b1;
    load_pos(100, 50, 1'b0, 0);
    set_pix(100, 50);
    checks++; if (rom_address !== 14'd0) begin errors++; $display("FAIL basic_addr got %0d want 0", rom_address); end
    checks++; if (pix_idx !== 4'd5) begin errors++; $display("FAIL basic_idx got %0d want 5", pix_idx); end
    checks++; if (pix_opaque !== 1'b1) begin errors++; $display("FAIL basic_opaque got %0b want 1", pix_opaque); end
    set_pix(99, 50);
    checks++; if (pix_opaque !== 1'b0) begin errors++; $display("FAIL left_miss got %0b want 0", pix_opaque); end
    checks++; if (pix_idx !== 4'd0) begin errors++; $display("FAIL left_miss_idx got %0d want 0", pix_idx); end
    set_pix(101, 51);
    checks++; if (rom_address !== 14'd65) begin errors++; $display("FAIL addr_65 got %0d want 65", rom_address); end
    set_pix(163, 113);
    checks++; if (rom_address !== 14'd4095) begin errors++; $display("FAIL addr_corner got %0d want 4095", rom_address); end
    checks++; if (pix_opaque !== 1'b1) begin errors++; $display("FAIL corner_opaque got %0b want 1", pix_opaque); end
    set_pix(164, 50);
    checks++; if (pix_opaque !== 1'b0) begin errors++; $display("FAIL right_miss got %0b want 0", pix_opaque); end
    set_pix(100, 114);
    checks++; if (pix_opaque !== 1'b0) begin errors++; $display("FAIL bottom_miss got %0b want 0", pix_opaque); end
  endtask

  task automatic test_scale_flip();
    load_pos(0, 0, 1'b1, 1);
    set_pix(127, 0);
    checks++; if (rom_address !== 14'd0) begin errors++; $display("FAIL s2_flip_edge got %0d want 0", rom_address); end
    checks++; if (pix_opaque !== 1'b1) begin errors++; $display("FAIL s2_flip_opaque got %0b want 1", pix_opaque); end
    set_pix(128, 0);
    checks++; if (pix_opaque !== 1'b0) begin errors++; $display("FAIL s2_miss got %0b want 1'b0", pix_opaque); end
    set_pix(0, 0);
    checks++; if (rom_address !== 14'd63) begin errors++; $display("FAIL s2_flip_left got %0d want 63", rom_address); end
    set_pix(2, 127);
    checks++; if (rom_address !== 14'd4094) begin errors++; $display("FAIL s2_flip_bottom got %0d want 4094", rom_address); end
    load_pos(0, 0, 1'b0, 2);
    set_pix(255, 255);
    checks++; if (rom_address !== 14'd4095) begin errors++; $display("FAIL s4_corner got %0d want 4095", rom_address); end
    checks++; if (pix_opaque !== 1'b1) begin errors++; $display("FAIL s4_opaque got %0b want 1", pix_opaque); end
    set_pix(255, 256);
    checks++; if (pix_opaque !== 1'b0) begin errors++; $display("FAIL s4_miss got %0b want 0", pix_opaque); end
    load_pos(0, 0, 1'b0, 3);
    set_pix(200, 4);
    checks++; if (rom_address !== 14'd114) begin errors++; $display("FAIL s3_as_4x got %0d want 114", rom_address); end
    load_pos(1000, 0, 1'b0, 0);
    set_pix(10, 0);
    checks++; if (pix_opaque !== 1'b0) begin errors++; $display("FAIL no_wrap got %0b want 0", pix_opaque); end
    set_pix(1023, 0);
    checks++; if (rom_address !== 14'd23) begin errors++; $display("FAIL clip_addr got %0d want 23", rom_address); end
    checks++; if (pix_opaque !== 1'b1) begin errors++; $display("FAIL clip_opaque got %0b want 1", pix_opaque); end
  endtask

  task automatic test_transparent();
    load_pos(100, 50, 1'b0, 0);
    rom_val = 4'd0;
    set_pix(110, 60);
    checks++; if (pix_opaque !== 1'b0) begin errors++; $display("FAIL transp_opaque got %0b want 0", pix_opaque); end
    checks++; if (pix_idx !== 4'd0) begin errors++; $display("FAIL transp_idx got %0d want 0", pix_idx); end
    rom_val = 4'd7;
    blank   = 1'b0;
    set_pix(110, 60);
    checks++; if (pix_opaque !== 1'b0) begin errors++; $display("FAIL blank_opaque got %0b want 0", pix_opaque); end
    checks++; if (pix_idx !== 4'd0) begin errors++; $display("FAIL blank_idx got %0d want 0", pix_idx); end
    blank = 1'b1;
    set_pix(110, 60);
    checks++; if (pix_idx !== 4'd7) begin errors++; $display("FAIL active_idx got %0d want 7", pix_idx); end
  endtask

  task automatic test_shadow();
    pos_x = 10'd200;
    set_pix(100, 50);
    checks++; if (rom_address !== 14'd0) begin errors++; $display("FAIL shadow_hold_addr got %0d want 0", rom_address); end
    checks++; if (pix_opaque !== 1'b1) begin errors++; $display("FAIL shadow_hold_opaque got %0b want 1", pix_opaque); end
    pulse_fs();
    set_pix(100, 50);
    checks++; if (pix_opaque !== 1'b0) begin errors++; $display("FAIL shadow_old_pos got %0b want 0", pix_opaque); end
    set_pix(200, 50);
    checks++; if (pix_opaque !== 1'b1) begin errors++; $display("FAIL shadow_new_pos got %0b want 1", pix_opaque); end
    checks++; if (rom_address !== 14'd0) begin errors++; $display("FAIL shadow_new_addr got %0d want 0", rom_address); end
  endtask

  task automatic test_anim();
    anim_en    = 1'b1;
    anim_loop  = 1'b1;
    anim_start = 1'b1;
    tick();
    anim_start = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      pulse_fs();
      if (i % 8 == 0 || i % 8 == 7) begin
        checks++;
        if (frame_idx !== 2'((i / 8) % 4)) begin
          errors++; $display("FAIL loop_frame pulse %0d got %0d want %0d", i, frame_idx, (i / 8) % 4);
        end
      end
    end
    anim_loop = 1'b0;
    for (int i = 1; i <= 31; i++) pulse_fs();
    checks++; if (frame_idx !== 2'd3) begin errors++; $display("FAIL oneshot_last got %0d want 3", frame_idx); end
    checks++; if (anim_done !== 1'b0) begin errors++; $display("FAIL oneshot_early_done got %0b want 0", anim_done); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (anim_done !== 1'b1) begin errors++; $display("FAIL oneshot_done got %0b want 1", anim_done); end
    checks++; if (frame_idx !== 2'd3) begin errors++; $display("FAIL oneshot_hold got %0d want 3", frame_idx); end
    repeat (8) pulse_fs();
    checks++; if (frame_idx !== 2'd3) begin errors++; $display("FAIL done_ignores got %0d want 3", frame_idx); end
    DrawX = 10'd200;
    DrawY = 10'd50;
    tick();
    checks++; if (rom_address !== 14'd12288) begin errors++; $display("FAIL frame3_base got %0d want 12288", rom_address); end
    anim_start  = 1'b1;
    frame_start = 1'b1;
    tick();
    anim_start  = 1'b0;
    frame_start = 1'b0;
    checks++; if (frame_idx !== 2'd0) begin errors++; $display("FAIL restart_frame got %0d want 0", frame_idx); end
    checks++; if (anim_done !== 1'b0) begin errors++; $display("FAIL restart_done got %0b want 0", anim_done); end
    anim_loop = 1'b1;
    repeat (7) pulse_fs();
    anim_start  = 1'b1;
    frame_start = 1'b1;
    tick();
    anim_start  = 1'b0;
    frame_start = 1'b0;
    checks++; if (frame_idx !== 2'd0) begin errors++; $display("FAIL start_wins got %0d want 0", frame_idx); end
    repeat (7) pulse_fs();
    checks++; if (frame_idx !== 2'd0) begin errors++; $display("FAIL counter_cleared got %0d want 0", frame_idx); end
    pulse_fs();
    checks++; if (frame_idx !== 2'd1) begin errors++; $display("FAIL step_after_restart got %0d want 1", frame_idx); end
    anim_en = 1'b0;
    repeat (8) pulse_fs();
    checks++; if (frame_idx !== 2'd1) begin errors++; $display("FAIL en_low_hold got %0d want 1", frame_idx); end
  endtask

  task automatic test_reset_mid();
    anim_en    = 1'b1;
    anim_loop  = 1'b1;
    anim_start = 1'b1;
    tick();
    anim_start = 1'b0;
    repeat (16) pulse_fs();
    checks++; if (frame_idx !== 2'd2) begin errors++; $display("FAIL pre_reset_frame got %0d want 2", frame_idx); end
    rom_val = 4'd5;
    set_pix(200, 50);
    checks++; if (rom_address !== 14'd8192) begin errors++; $display("FAIL frame2_base got %0d want 8192", rom_address); end
    checks++; if (pix_opaque !== 1'b1) begin errors++; $display("FAIL pre_reset_opaque got %0b want 1", pix_opaque); end
    #2 reset = 1'b1;
    #1;
    checks++; if (rom_address !== 14'd0) begin errors++; $display("FAIL mid_reset_addr got %0d want 0", rom_address); end
    checks++; if (pix_idx !== 4'd0) begin errors++; $display("FAIL mid_reset_idx got %0d want 0", pix_idx); end
    checks++; if (pix_opaque !== 1'b0) begin errors++; $display("FAIL mid_reset_opaque got %0b want 0", pix_opaque); end
    checks++; if (frame_idx !== 2'd0) begin errors++; $display("FAIL mid_reset_frame got %0d want 0", frame_idx); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (frame_idx !== 2'd0) begin errors++; $display("FAIL post_reset_frame got %0d want 0", frame_idx); end
    checks++; if (pix_opaque !== 1'b0) begin errors++; $display("FAIL post_reset_opaque got %0b want 0", pix_opaque); end
    checks++; if (rom_address !== 14'd0) begin errors++; $display("FAIL post_reset_addr got %0d want 0", rom_address); end
  endtask

  initial begin
    reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0; frame_start = 1'b0;
    pos_x = '0; pos_y = '0; flip_x = 1'b0; scale = '0;
    anim_start = 1'b0; anim_en = 1'b0; anim_loop = 1'b0; rom_val = '0;
    test_reset();
    test_basic();
    test_scale_flip();
    test_transparent();
    test_shadow();
    test_anim();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks %0d", checks);
    $fatal(1);
  end

endmodule
